alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, two-stage pipelined ALU that succeeds the single-cycle execute-stage ALU. It sits between the decoder and writeback. It adds:
- valid/ready handshakes on both sides;
- a registered NZCV flags register plus a sticky saturation (Q) flag;
- carry-in ops (ADC/SBC) and signed saturating add/subtract;
- a back-to-back result-forwarding path on operand 1.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits (≥8).
- SAT_EN, 1, 1 = QADD/QSUB saturate; 0 = they behave as ADD/SUB and Q never sets.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decoder presents an operation.
- in_ready  out  1  = !s1_valid || s1_adv; transfer when in_valid && in_ready.
- decoder_operand0  in  WIDTH  operand 0.
- decoder_operand1  in  WIDTH  operand 1 when sel = 00 or 11.
- mem_wr_data  in  WIDTH  operand 1 when sel = 10.
- sel  in  2  operand-1 source: 00 decoder, 01 forwarded last result, 10 mem_wr_data, 11 decoder (reserved).
- operation  in  4  opcode, see Operation.
- update_flags  in  1  write NZCV for this op.
- use_flags  in  1  ADC/SBC take carry-in from C; otherwise carry-in is 0 for ADC and 1 for SBC.
- clear_q  in  1  synchronous clear of Q; set has priority on the same edge.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts; transfer when out_valid && out_ready.
- alu_op  out  WIDTH  result.
- flags  out  4  registered {N,Z,C,V}.
- q_flag  out  1  sticky saturation flag.

## Operation
- **Stage 1 (S1):** registers operand0, decoder_operand1, mem_wr_data, sel, operation, update_flags and use_flags on input transfer.
- **Stage 2 (S2):**
  - s1_adv = s1_valid && (!out_valid || out_ready).
  - On s1_adv, operand 1 is muxed from the S1 fields. sel = 01 selects last_result.
  - The result is computed and loaded into alu_op, and into last_result on the same edge.
  - out_valid is set; s1_valid clears unless a new input transfers on the same edge.
- **last_result** always holds the most recently computed result in issue order, whether or not it has been consumed. Back-to-back dependent ops therefore forward with no bubble.
- **Opcodes** (a = operand0, b = muxed operand 1):
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOT b, 1010 MOV b.
  - 0100 ADD a+b, 0101 SUB a−b, 0110 ADC a+b+cin, 0111 SBC a+~b+cin.
  - 1000 QADD, 1001 QSUB.
  - 1011 CMP: result = a−b; writeback should ignore it.
  - 11xx: result 0, flags untouched regardless of update_flags.
- **Arithmetic:**
  - Computed at WIDTH+1 bits.
  - C = bit WIDTH. For subtract, C = NOT borrow (a ≥ b unsigned ⇒ C = 1).
  - V = signed overflow.
- **Saturation (QADD/QSUB):**
  - On signed overflow, the result clamps to 0x7F..F (positive) or 0x80..0 (negative).
  - Q is set on any saturating clamp, independent of update_flags.
  - V reflects the unsaturated overflow.
- **Flags update** (only on s1_adv with update_flags = 1):
  - Logic ops and MOV update N and Z only.
  - Arithmetic ops update all four.
  - N = result[WIDTH−1]; Z = (result == 0).
  - ADC/SBC read C as it stands before this op's update. Forwarding of C between back-to-back ops is by the same register.
- **Reset:** asynchronous; all state clears immediately, including any op in flight, which is discarded.

## Timing
- Reset values:
  - in_ready = 1;
  - out_valid = 0;
  - alu_op = 0;
  - last_result = 0;
  - flags = 0000;
  - q_flag = 0;
  - s1_valid = 0.
- Latency: input transfer at edge k ⇒ out_valid and alu_op at edge k+1 at the earliest.
- Throughput: 1 op/cycle when out_ready is held high.
- Backpressure:
  - out_valid && !out_ready holds alu_op, flags and out_valid stable.
  - S1 holds its op; in_ready drops if S1 is full.
  - S1 is never overwritten without advancing.
- Simultaneous events:
  - Output consume plus S1 advance on the same edge loads the new result; out_valid stays 1.
  - Input transfer plus S1 advance on the same edge means S1 is refilled.
- out_valid falls only on a consume with no S1 advance.
- Flags and Q change only on the advancing edge of the op that writes them.

## Test plan
- **Reset mid-flight:** with S1 and S2 both full, assert rst asynchronously ⇒ out_valid = 0, flags = 0, in_ready = 1 before the next edge.
- **Streaming with flags:** out_ready = 1; issue ADD 0xFFFFFFFF+1 with update_flags, then ADC 0+0 with use_flags.
  - ADD ⇒ alu_op = 0, NZCV = 0110.
  - ADC ⇒ alu_op = 1 (cin = 1).
- **Forwarding chain:** MOV b = 5 (sel 00), then ADD a = 3 with sel 01, then ADD a = 1 with sel 01, issued back-to-back ⇒ results 5, 8, 9 on consecutive cycles.
- **Saturation:** QADD 0x7FFFFFF0+0x20 ⇒ 0x7FFFFFFF, q_flag = 1, V = 1.
  - Then QSUB 0x80000000−1 ⇒ 0x80000000.
  - Then clear_q ⇒ q_flag = 0.
- **Backpressure:** hold out_ready = 0 for 3 cycles after one result; issue 2 more ops.
  - alu_op is held; the second op waits in S1; in_ready = 0 for the third op.
  - Release out_ready ⇒ results drain in order, none lost or duplicated.
- **CMP and unused opcodes:** CMP 4,4 with update_flags ⇒ Z = 1, C = 1. Opcode 1100 with update_flags ⇒ alu_op = 0, flags unchanged.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the decoder, alu_pipe and writeback.
// The master modport is the decoder/writeback side; the slave modport is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] decoder_operand0;
  logic [WIDTH-1:0] decoder_operand1;
  logic [WIDTH-1:0] mem_wr_data;
  logic [1:0]       sel;
  logic [3:0]       operation;
  logic             update_flags;
  logic             use_flags;
  logic             clear_q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_op;
  logic [3:0]       flags;
  logic             q_flag;

  modport master (
    output in_valid, decoder_operand0, decoder_operand1, mem_wr_data, sel,
           operation, update_flags, use_flags, clear_q, out_ready,
    input  in_ready, out_valid, alu_op, flags, q_flag
  );

  modport slave (
    input  in_valid, decoder_operand0, decoder_operand1, mem_wr_data, sel,
           operation, update_flags, use_flags, clear_q, out_ready,
    output in_ready, out_valid, alu_op, flags, q_flag
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds the accepted op, S2 computes and presents the
// result together with registered NZCV flags, sticky Q and last-result forwarding.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_op0_r;
  logic [WIDTH-1:0] s1_op1_r;
  logic [WIDTH-1:0] s1_mem_r;
  logic [1:0]       s1_sel_r;
  logic [3:0]       s1_operation_r;
  logic             s1_upd_r;
  logic             s1_use_r;

  logic             out_valid_r;
  logic [WIDTH-1:0] alu_op_r;
  logic [WIDTH-1:0] last_result_r;
  logic [3:0]       flags_r;
  logic             q_r;

  logic             s1_adv_s;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic             is_sub_s;
  logic             cin_s;
  logic             ovf_s;
  logic             sat_s;
  logic [WIDTH-1:0] result_s;
  logic [3:0]       flags_next_s;

  assign s1_adv_s   = s1_valid_r && (!out_valid_r || bus.out_ready);
  assign in_ready_s = !s1_valid_r || s1_adv_s;
  assign in_xfer_s  = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.flags     = flags_r;
  assign bus.q_flag    = q_r;

  // Operand-1 source mux; sel 01 forwards the most recently computed result.
  always_comb begin
    b_s = s1_op1_r;
    case (s1_sel_r)
      2'b01:   b_s = last_result_r;
      2'b10:   b_s = s1_mem_r;
      default: b_s = s1_op1_r;
    endcase
  end

  // Shared WIDTH+1 adder: subtracts are a + ~b + cin, so the carry out is NOT borrow.
  always_comb begin
    is_sub_s = 1'b0;
    cin_s    = 1'b0;
    case (s1_operation_r)
      4'b0101, 4'b1001, 4'b1011: begin
        is_sub_s = 1'b1;
        cin_s    = 1'b1;
      end
      4'b0110: begin
        is_sub_s = 1'b0;
        cin_s    = s1_use_r ? flags_r[1] : 1'b0;
      end
      4'b0111: begin
        is_sub_s = 1'b1;
        cin_s    = s1_use_r ? flags_r[1] : 1'b1;
      end
      default: begin
        is_sub_s = 1'b0;
        cin_s    = 1'b0;
      end
    endcase
    b_eff_s = is_sub_s ? ~b_s : b_s;
    sum_s   = {1'b0, s1_op0_r} + {1'b0, b_eff_s} + {ZERO, cin_s};
    ovf_s   = (s1_op0_r[WIDTH-1] == b_eff_s[WIDTH-1]) &&
              (sum_s[WIDTH-1] != s1_op0_r[WIDTH-1]);
  end

  // Result select, saturation and next flag value.
  always_comb begin
    result_s = ZERO;
    sat_s    = 1'b0;
    case (s1_operation_r)
      4'b0000: result_s = s1_op0_r & b_s;
      4'b0001: result_s = s1_op0_r | b_s;
      4'b0010: result_s = s1_op0_r ^ b_s;
      4'b0011: result_s = ~b_s;
      4'b1010: result_s = b_s;
      4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1011: result_s = sum_s[WIDTH-1:0];
      4'b1000, 4'b1001: begin
        // Positive overflow is only possible when operand 0 is non-negative.
        if (SAT_EN && ovf_s) begin
          result_s = s1_op0_r[WIDTH-1] ? SAT_NEG : SAT_POS;
          sat_s    = 1'b1;
        end else begin
          result_s = sum_s[WIDTH-1:0];
        end
      end
      default: result_s = ZERO;
    endcase

    flags_next_s = flags_r;
    if (s1_upd_r) begin
      case (s1_operation_r)
        4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1010:
          flags_next_s[3:2] = {result_s[WIDTH-1], (result_s == ZERO)};
        4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1011:
          flags_next_s = {result_s[WIDTH-1], (result_s == ZERO), sum_s[WIDTH], ovf_s};
        default: flags_next_s = flags_r;
      endcase
    end else begin
      flags_next_s = flags_r;
    end
  end

  // S1 register: captures on input transfer, empties when it advances without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r     <= 1'b0;
      s1_op0_r       <= ZERO;
      s1_op1_r       <= ZERO;
      s1_mem_r       <= ZERO;
      s1_sel_r       <= 2'b00;
      s1_operation_r <= 4'b0000;
      s1_upd_r       <= 1'b0;
      s1_use_r       <= 1'b0;
    end else if (in_xfer_s) begin
      s1_valid_r     <= 1'b1;
      s1_op0_r       <= bus.decoder_operand0;
      s1_op1_r       <= bus.decoder_operand1;
      s1_mem_r       <= bus.mem_wr_data;
      s1_sel_r       <= bus.sel;
      s1_operation_r <= bus.operation;
      s1_upd_r       <= bus.update_flags;
      s1_use_r       <= bus.use_flags;
    end else if (s1_adv_s) begin
      s1_valid_r     <= 1'b0;
    end
  end

  // S2 register: result, forwarding copy and flags load together on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      alu_op_r      <= ZERO;
      last_result_r <= ZERO;
      flags_r       <= 4'b0000;
    end else if (s1_adv_s) begin
      out_valid_r   <= 1'b1;
      alu_op_r      <= result_s;
      last_result_r <= result_s;
      flags_r       <= flags_next_s;
    end else if (bus.out_ready) begin
      out_valid_r   <= 1'b0;
    end
  end

  // Sticky saturation flag; a clamp on the same edge wins over clear_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (s1_adv_s && sat_s) begin
      q_r <= 1'b1;
    end else if (bus.clear_q) begin
      q_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe against an issue-order reference model.
module tb_alu_pipe;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint U32  = 64'sd4294967296;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b1;
    logic [31:0] mem;
    logic [1:0]  sel;
    logic [3:0]  opc;
    logic        upd;
    logic        use_f;
  } op_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
    logic        q;
  } exp_t;

  logic clk;
  logic rst;
  alu_pipe_if #(.WIDTH(32)) bus ();

  alu_pipe #(.WIDTH(32), .SAT_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  exp_t exp_q[$];
  exp_t dut_log[$];
  int   inflight    = 0;
  bit   just_issued = 1'b0;
  logic [3:0]  m_flags = 4'b0000;
  logic        m_q     = 1'b0;
  logic [31:0] m_last  = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] sel, input bit upd, input bit use_f);
    op_t o;
    o.a = a; o.b1 = b; o.sel = sel; o.opc = opc; o.upd = upd; o.use_f = use_f;
    o.mem = (sel == 2'b10) ? b : ~b;
    return o;
  endfunction

  // Reference: evaluates each op in issue order with exact integer arithmetic.
  task automatic model_issue(input op_t o);
    logic [31:0] b, res;
    longint ua, ub, sa, sb, full, ideal;
    bit arith, logic_op, cin, c, v, add_type;
    b  = (o.sel == 2'b01) ? m_last : ((o.sel == 2'b10) ? o.mem : o.b1);
    ua = longint'({32'd0, o.a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(o.a));
    sb = longint'($signed(b));
    if (o.opc == 4'b0110) cin = o.use_f ? m_flags[1] : 1'b0;
    else                  cin = o.use_f ? m_flags[1] : 1'b1;
    arith = 1'b1; logic_op = 1'b0; full = 0; ideal = 0; res = 32'h0;
    add_type = (o.opc == 4'b0100) || (o.opc == 4'b0110) || (o.opc == 4'b1000);
    case (o.opc)
      4'b0000: begin res = o.a & b; logic_op = 1'b1; arith = 1'b0; end
      4'b0001: begin res = o.a | b; logic_op = 1'b1; arith = 1'b0; end
      4'b0010: begin res = o.a ^ b; logic_op = 1'b1; arith = 1'b0; end
      4'b0011: begin res = ~b;      logic_op = 1'b1; arith = 1'b0; end
      4'b1010: begin res = b;       logic_op = 1'b1; arith = 1'b0; end
      4'b0100, 4'b1000:          begin full = ua + ub; ideal = sa + sb; end
      4'b0110:                   begin full = ua + ub + longint'(cin); ideal = sa + sb + longint'(cin); end
      4'b0101, 4'b1001, 4'b1011: begin full = ua - ub; ideal = sa - sb; end
      4'b0111:                   begin full = ua - ub - 1 + longint'(cin); ideal = sa - sb - 1 + longint'(cin); end
      default: arith = 1'b0;
    endcase
    c = 1'b0; v = 1'b0;
    if (arith) begin
      res = 32'(full);
      c   = add_type ? (full >= U32) : (full >= 0);
      v   = (ideal > SMAX) || (ideal < SMIN);
      if ((o.opc == 4'b1000 || o.opc == 4'b1001) && v) begin
        res = (ideal > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        m_q = 1'b1;
      end
    end
    if (o.upd && logic_op) m_flags[3:2] = {res[31], res == 32'h0};
    else if (o.upd && arith) m_flags = {res[31], res == 32'h0, c, v};
    m_last = res;
    exp_q.push_back({res, m_flags, m_q});
  endtask

  // Compare process: every cycle out of reset, check handshake and held output.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", bus.out_valid, (inflight - int'(just_issued)) > 0);
      chk("in_ready", bus.in_ready, !(inflight == 2 && !bus.out_ready));
      if (bus.out_valid && exp_q.size() > 0) begin
        chk("alu_op", bus.alu_op, exp_q[0].res);
        chk("flags", bus.flags, exp_q[0].fl);
        chk("q_flag", bus.q_flag, exp_q[0].q);
      end
    end
  end

  task automatic cycle(input bit v, input op_t o, input bit ordy, input bit clrq, output bit xfer);
    bit cons;
    @(negedge clk);
    #1;
    bus.in_valid = v;
    bus.decoder_operand0 = o.a;
    bus.decoder_operand1 = o.b1;
    bus.mem_wr_data = o.mem;
    bus.sel = o.sel;
    bus.operation = o.opc;
    bus.update_flags = o.upd;
    bus.use_flags = o.use_f;
    bus.out_ready = ordy;
    bus.clear_q = clrq;
    #1;
    xfer = v && bus.in_ready;
    cons = bus.out_valid && ordy;
    if (cons) begin
      dut_log.push_back({bus.alu_op, bus.flags, bus.q_flag});
      void'(exp_q.pop_front());
    end
    if (xfer) model_issue(o);
    if (clrq) m_q = 1'b0;
    inflight = inflight + int'(xfer) - int'(cons);
    just_issued = xfer;
  endtask

  task automatic send(input op_t o, input bit ordy);
    bit x;
    int n;
    x = 1'b0; n = 0;
    while (!x && n < 20) begin
      cycle(1'b1, o, ordy, 1'b0, x);
      n++;
    end
    if (!x) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no acceptance after %0d cycles, want acceptance", n);
    end
  endtask

  task automatic drain();
    bit x;
    int n;
    n = 0;
    while (inflight > 0 && n < 10) begin
      cycle(1'b0, mk(4'b0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0), 1'b1, 1'b0, x);
      n++;
    end
    cycle(1'b0, mk(4'b0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0), 1'b1, 1'b0, x);
    if (inflight != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d ops in flight, want 0", inflight);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit x;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.decoder_operand0 = 32'h0; bus.decoder_operand1 = 32'h0;
    bus.mem_wr_data = 32'h0; bus.sel = 2'b00; bus.operation = 4'b0000;
    bus.update_flags = 1'b0; bus.use_flags = 1'b0; bus.clear_q = 1'b0; bus.out_ready = 1'b1;
    #7;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_alu_op", bus.alu_op, 32'h0);
    chk("rst_flags", bus.flags, 4'b0000);
    chk("rst_q", bus.q_flag, 1'b0);
    @(negedge clk); #1; rst = 1'b0;

    // Streaming with flags: ADD then ADC using the carry it produced.
    dut_log.delete();
    send(mk(4'b0100, 32'hFFFF_FFFF, 32'h1, 2'b00, 1'b1, 1'b0), 1'b1);
    send(mk(4'b0110, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1), 1'b1);
    drain();
    chk("stream_count", dut_log.size(), 2);
    if (dut_log.size() == 2) begin
      chk("stream_add_res", dut_log[0].res, 32'h0);
      chk("stream_add_nzcv", dut_log[0].fl, 4'b0110);
      chk("stream_adc_res", dut_log[1].res, 32'h1);
    end

    // Forwarding chain 5, 8, 9.
    dut_log.delete();
    send(mk(4'b1010, 32'h0, 32'h5, 2'b00, 1'b0, 1'b0), 1'b1);
    send(mk(4'b0100, 32'h3, 32'hDEAD, 2'b01, 1'b0, 1'b0), 1'b1);
    send(mk(4'b0100, 32'h1, 32'hBEEF, 2'b01, 1'b0, 1'b0), 1'b1);
    drain();
    chk("fwd_count", dut_log.size(), 3);
    if (dut_log.size() == 3) begin
      chk("fwd_0", dut_log[0].res, 32'h5);
      chk("fwd_1", dut_log[1].res, 32'h8);
      chk("fwd_2", dut_log[2].res, 32'h9);
    end

    // Saturation and clear_q.
    dut_log.delete();
    send(mk(4'b1000, 32'h7FFF_FFF0, 32'h20, 2'b00, 1'b1, 1'b0), 1'b1);
    send(mk(4'b1001, 32'h8000_0000, 32'h1, 2'b10, 1'b1, 1'b0), 1'b1);
    drain();
    chk("sat_count", dut_log.size(), 2);
    if (dut_log.size() == 2) begin
      chk("qadd_res", dut_log[0].res, 32'h7FFF_FFFF);
      chk("qadd_nzcv", dut_log[0].fl, 4'b0001);
      chk("qadd_q", dut_log[0].q, 1'b1);
      chk("qsub_res", dut_log[1].res, 32'h8000_0000);
      chk("qsub_nzcv", dut_log[1].fl, 4'b1011);
    end
    cycle(1'b0, mk(4'b0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0), 1'b1, 1'b1, x);
    cycle(1'b0, mk(4'b0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0), 1'b1, 1'b0, x);
    chk("clear_q", bus.q_flag, 1'b0);

    // CMP and an unused opcode.
    dut_log.delete();
    send(mk(4'b1011, 32'h4, 32'h4, 2'b00, 1'b1, 1'b0), 1'b1);
    send(mk(4'b1100, 32'h7, 32'h9, 2'b00, 1'b1, 1'b0), 1'b1);
    drain();
    chk("cmp_count", dut_log.size(), 2);
    if (dut_log.size() == 2) begin
      chk("cmp_nzcv", dut_log[0].fl, 4'b0110);
      chk("op1100_res", dut_log[1].res, 32'h0);
      chk("op1100_nzcv", dut_log[1].fl, 4'b0110);
    end

    // Backpressure: A in S2 held, B waits in S1, C refused until release.
    dut_log.delete();
    send(mk(4'b0100, 32'h1, 32'h2, 2'b00, 1'b0, 1'b0), 1'b1);
    cycle(1'b1, mk(4'b0100, 32'd10, 32'd20, 2'b00, 1'b0, 1'b0), 1'b0, 1'b0, x);
    chk("bp_b_accepted", x, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, mk(4'b0100, 32'd100, 32'd200, 2'b00, 1'b0, 1'b0), 1'b0, 1'b0, x);
      chk("bp_c_refused", x, 1'b0);
    end
    chk("bp_held", bus.alu_op, 32'd3);
    send(mk(4'b0100, 32'd100, 32'd200, 2'b00, 1'b0, 1'b0), 1'b1);
    drain();
    chk("bp_count", dut_log.size(), 3);
    if (dut_log.size() == 3) begin
      chk("bp_0", dut_log[0].res, 32'd3);
      chk("bp_1", dut_log[1].res, 32'd30);
      chk("bp_2", dut_log[2].res, 32'd300);
    end

    // Reset mid-flight with S1 and S2 full.
    cycle(1'b1, mk(4'b0100, 32'hFFFF_FFFF, 32'h2, 2'b00, 1'b1, 1'b0), 1'b0, 1'b0, x);
    cycle(1'b1, mk(4'b0001, 32'h5, 32'h6, 2'b00, 1'b0, 1'b0), 1'b0, 1'b0, x);
    @(posedge clk); #2;
    chk("mid_full_in_ready", bus.in_ready, 1'b0);
    chk("mid_flags_before", bus.flags, 4'b0010);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_out_valid", bus.out_valid, 1'b0);
    chk("mid_flags", bus.flags, 4'b0000);
    chk("mid_in_ready", bus.in_ready, 1'b1);
    exp_q.delete();
    inflight = 0; just_issued = 1'b0;
    m_flags = 4'b0000; m_q = 1'b0; m_last = 32'h0;
    @(negedge clk); #1; rst = 1'b0;

    // Random traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7,
            mk(4'($urandom_range(0, 15)), pick(), pick(), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
            $urandom_range(0, 9) < 7, 1'b0, x);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
